ncc_top: RTL and testbench

// - Line-streaming accumulator for normalized cross-correlation (NCC) template matching.
// - Every clock it takes one image line I and one line of each of NUM_TEMPLATES templates T.
// - It accumulates three kinds of sum over the lines received since reset:
//   sum(I), sum(I^2), and sum(T_k*I) for each template k.
// - Feeds the downstream NCC score / normalization stage.

---
 rtl/ncc_pkg.sv | 19 +
 rtl/ncc_line_mac.sv | 34 +++
 rtl/ncc_top.sv | 72 +++++++
 tb/tb_ncc_top.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ncc_pkg.sv
// Shared sizing and types for the NCC line-streaming accumulator.
// ACC_W leaves enough headroom for NUM_OF_LINES full-scale lines.
package ncc_pkg;

    localparam int PIXEL_SIZE    = 8;
    localparam int LINE_SIZE     = 8;
    localparam int NUM_TEMPLATES = 4;
    localparam int NUM_OF_LINES  = 8;

    localparam int PROD_W = 2 * PIXEL_SIZE;
    localparam int LS_W   = $clog2(LINE_SIZE) + PROD_W;
    localparam int ACC_W  = $clog2(NUM_OF_LINES) + LS_W;

    typedef logic [PIXEL_SIZE-1:0] pixel_t;
    typedef logic [PROD_W-1:0]     prod_t;
    typedef logic [LS_W-1:0]       line_sum_t;
    typedef logic [ACC_W-1:0]      acc_t;

endpackage

// File: rtl/ncc_line_mac.sv
// One line of pixel products summed by an adder tree, registered once.
// With BYPASS set the b operand is ignored and the line sum is sum(a).
module line_mac
    import ncc_pkg::*;
#(
    parameter bit BYPASS = 1'b0
) (
    input  logic      clk,
    input  logic      rst_n,
    input  pixel_t    a [LINE_SIZE],
    input  pixel_t    b [LINE_SIZE],
    output line_sum_t line_sum
);

    line_sum_t sum_comb;

    // Line sum width covers LINE_SIZE full-scale products, so nothing is lost here.
    always_comb begin
        sum_comb = '0;
        for (int j = 0; j < LINE_SIZE; j++) begin
            sum_comb = sum_comb + line_sum_t'(BYPASS ? prod_t'(a[j])
                                                     : prod_t'(a[j]) * prod_t'(b[j]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_sum <= '0;
        end else begin
            line_sum <= sum_comb;
        end
    end

endmodule

// File: rtl/ncc_top.sv
// NCC accumulator: per-line sums of I, I^2 and T_k*I, accumulated since reset.
// Two-cycle latency: line sums registered in line_mac, then added here.
module ncc_top
    import ncc_pkg::*;
(
    input  logic                  CLK,
    input  logic                  reset,
    input  logic [PIXEL_SIZE-1:0] I_in_line [LINE_SIZE],
    input  logic [PIXEL_SIZE-1:0] T_in_line [LINE_SIZE][NUM_TEMPLATES],
    output logic [ACC_W-1:0]      Acc_lines_sum_I_square,
    output logic [ACC_W-1:0]      Acc_lines_sum_I,
    output logic [ACC_W-1:0]      Acc_lines_sum_T_x_I_out_top [NUM_TEMPLATES]
);

    pixel_t    t_col [NUM_TEMPLATES][LINE_SIZE];
    line_sum_t ls_i2;
    line_sum_t ls_i;
    line_sum_t ls_ti [NUM_TEMPLATES];

    // Regroup the template input so each MAC sees one template's line.
    always_comb begin
        for (int k = 0; k < NUM_TEMPLATES; k++) begin
            for (int j = 0; j < LINE_SIZE; j++) begin
                t_col[k][j] = T_in_line[j][k];
            end
        end
    end

    line_mac #(.BYPASS(1'b0)) u_mac_i2 (
        .clk      (CLK),
        .rst_n    (reset),
        .a        (I_in_line),
        .b        (I_in_line),
        .line_sum (ls_i2)
    );

    line_mac #(.BYPASS(1'b1)) u_mac_i (
        .clk      (CLK),
        .rst_n    (reset),
        .a        (I_in_line),
        .b        (I_in_line),
        .line_sum (ls_i)
    );

    for (genvar k = 0; k < NUM_TEMPLATES; k++) begin : g_tmpl
        line_mac #(.BYPASS(1'b0)) u_mac_ti (
            .clk      (CLK),
            .rst_n    (reset),
            .a        (I_in_line),
            .b        (t_col[k]),
            .line_sum (ls_ti[k])
        );
    end

    // Accumulators wrap modulo 2^ACC_W past NUM_OF_LINES full-scale lines.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            Acc_lines_sum_I_square <= '0;
            Acc_lines_sum_I        <= '0;
            for (int k = 0; k < NUM_TEMPLATES; k++) begin
                Acc_lines_sum_T_x_I_out_top[k] <= '0;
            end
        end else begin
            Acc_lines_sum_I_square <= Acc_lines_sum_I_square + acc_t'(ls_i2);
            Acc_lines_sum_I        <= Acc_lines_sum_I + acc_t'(ls_i);
            for (int k = 0; k < NUM_TEMPLATES; k++) begin
                Acc_lines_sum_T_x_I_out_top[k] <= Acc_lines_sum_T_x_I_out_top[k] + acc_t'(ls_ti[k]);
            end
        end
    end

endmodule

// File: tb/tb_ncc_top.sv
// Directed bench for ncc_top: hand-computed sums plus a small reference model for random lines.
module tb_ncc_top;
    import ncc_pkg::*;

    logic                  CLK;
    logic                  reset;
    logic [PIXEL_SIZE-1:0] i_line [LINE_SIZE];
    logic [PIXEL_SIZE-1:0] t_line [LINE_SIZE][NUM_TEMPLATES];
    logic [ACC_W-1:0]      sum_i2;
    logic [ACC_W-1:0]      sum_i;
    logic [ACC_W-1:0]      sum_ti [NUM_TEMPLATES];

    int checks = 0;
    int errors = 0;

    logic [ACC_W-1:0] m_acc_i2, m_acc_i;
    logic [ACC_W-1:0] m_acc_ti [NUM_TEMPLATES];
    logic [ACC_W-1:0] m_ls_i2, m_ls_i;
    logic [ACC_W-1:0] m_ls_ti [NUM_TEMPLATES];

    ncc_top dut (
        .CLK                         (CLK),
        .reset                       (reset),
        .I_in_line                   (i_line),
        .T_in_line                   (t_line),
        .Acc_lines_sum_I_square      (sum_i2),
        .Acc_lines_sum_I             (sum_i),
        .Acc_lines_sum_T_x_I_out_top (sum_ti)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [ACC_W-1:0] got, input logic [ACC_W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [ACC_W-1:0] e_i,
                             input logic [ACC_W-1:0] e_i2, input logic [ACC_W-1:0] e_ti);
        check({tag, " sum_I"}, sum_i, e_i);
        check({tag, " sum_I2"}, sum_i2, e_i2);
        for (int k = 0; k < NUM_TEMPLATES; k++) begin
            check($sformatf("%s T_x_I[%0d]", tag, k), sum_ti[k], e_ti);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, " sum_I"}, sum_i, m_acc_i);
        check({tag, " sum_I2"}, sum_i2, m_acc_i2);
        for (int k = 0; k < NUM_TEMPLATES; k++) begin
            check($sformatf("%s T_x_I[%0d]", tag, k), sum_ti[k], m_acc_ti[k]);
        end
    endtask

    task automatic drive_const(input int iv, input int tv);
        for (int j = 0; j < LINE_SIZE; j++) begin
            i_line[j] = pixel_t'(iv);
            for (int k = 0; k < NUM_TEMPLATES; k++) t_line[j][k] = pixel_t'(tv);
        end
    endtask

    task automatic clear_model();
        m_acc_i2 = '0; m_acc_i = '0; m_ls_i2 = '0; m_ls_i = '0;
        for (int k = 0; k < NUM_TEMPLATES; k++) begin
            m_acc_ti[k] = '0;
            m_ls_ti[k]  = '0;
        end
    endtask

    // One clock edge; the model consumes the line present at that edge.
    task automatic step();
        int s_i, s_i2;
        int s_ti [NUM_TEMPLATES];
        s_i = 0; s_i2 = 0;
        for (int k = 0; k < NUM_TEMPLATES; k++) s_ti[k] = 0;
        for (int j = 0; j < LINE_SIZE; j++) begin
            s_i  += int'(i_line[j]);
            s_i2 += int'(i_line[j]) * int'(i_line[j]);
            for (int k = 0; k < NUM_TEMPLATES; k++) s_ti[k] += int'(t_line[j][k]) * int'(i_line[j]);
        end
        @(posedge CLK);
        if (reset) begin
            m_acc_i  = m_acc_i + m_ls_i;
            m_acc_i2 = m_acc_i2 + m_ls_i2;
            m_ls_i   = ACC_W'(s_i);
            m_ls_i2  = ACC_W'(s_i2);
            for (int k = 0; k < NUM_TEMPLATES; k++) begin
                m_acc_ti[k] = m_acc_ti[k] + m_ls_ti[k];
                m_ls_ti[k]  = ACC_W'(s_ti[k]);
            end
        end
        @(negedge CLK);
    endtask

    task automatic pulse_reset(input string tag);
        #1 reset = 1'b0;
        clear_model();
        #1 check_all({tag, " in reset"}, '0, '0, '0);
        @(negedge CLK);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        drive_const(0, 0);
        clear_model();
        #2 check_all("reset asserted", '0, '0, '0);
        @(negedge CLK);
        @(negedge CLK);
        check_all("reset hold", '0, '0, '0);
        reset = 1'b1;

        for (int n = 0; n < 5; n++) begin
            step();
            check_all($sformatf("zeros %0d", n), '0, '0, '0);
        end

        // I=1, T=2: one line gives 8 / 8 / 16.
        pulse_reset("pre ones");
        drive_const(1, 2);
        step();
        check_all("ones latency1", '0, '0, '0);
        step();
        check_all("ones 1 line", 22'd8, 22'd8, 22'd16);
        step();
        drive_const(0, 0);
        step();
        check_all("ones 3 lines", 22'd24, 22'd24, 22'd48);
        step();
        check_all("ones hold", 22'd24, 22'd24, 22'd48);

        // Full scale, 8 lines: no overflow.
        pulse_reset("pre full8");
        drive_const(255, 255);
        for (int n = 0; n < 8; n++) step();
        drive_const(0, 0);
        step();
        check_all("full 8 lines", 22'd16320, 22'd4161600, 22'd4161600);

        // Full scale, 9 lines: 4681800 wraps to 487496.
        pulse_reset("pre full9");
        drive_const(255, 255);
        for (int n = 0; n < 9; n++) step();
        drive_const(0, 0);
        step();
        check_all("full 9 lines wrap", 22'd18360, 22'd487496, 22'd487496);

        // Reset mid-stream, then restart identical to a fresh start.
        pulse_reset("pre mid");
        drive_const(1, 2);
        step();
        step();
        check_all("mid before reset", 22'd8, 22'd8, 22'd16);
        step();
        pulse_reset("mid stream");
        drive_const(1, 2);
        step();
        check_all("mid restart latency", '0, '0, '0);
        step();
        step();
        drive_const(0, 0);
        step();
        check_all("mid restart 3 lines", 22'd24, 22'd24, 22'd48);

        // Random lines checked every cycle against the model, reset every 5 lines.
        pulse_reset("pre random");
        for (int n = 0; n < 10; n++) begin
            if (n == 5) pulse_reset("random mid");
            for (int j = 0; j < LINE_SIZE; j++) begin
                i_line[j] = pixel_t'($urandom_range(255, 0));
                for (int k = 0; k < NUM_TEMPLATES; k++) t_line[j][k] = pixel_t'($urandom_range(255, 0));
            end
            step();
            check_model($sformatf("random %0d", n));
        end
        drive_const(0, 0);
        step();
        check_model("random drain");
        step();
        check_model("random final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
